// File: rtl/spi_target_stream.sv
// SPI target with synchronised pin front end, TX FIFO and RX valid/ready stream.
// Any SPI mode; the system clock must run at least 8x the SPI clock.
module spi_target_stream #(
   parameter int WORD_W = 8,
   parameter int CPOL = 0,
   parameter int CPHA = 0,
   parameter int TX_DEPTH = 4,
   parameter logic [WORD_W-1:0] FILL_WORD = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              SPI_CLK,
   input  logic              SPI_CS,
   input  logic              SPI_PICO,
   output logic              SPI_POCI,
   output logic              spi_poci_oe,
   input  logic [WORD_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [WORD_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              rx_overrun,
   output logic              tx_underrun,
   output logic              frame_abort,
   output logic [7:0]        frame_cnt
);

   localparam int AW = $clog2(TX_DEPTH);
   localparam int CW = $clog2(WORD_W);
   localparam logic [CW-1:0] LAST = CW'(WORD_W - 1);
   localparam logic CLK_IDLE = (CPOL != 0);
   localparam logic SMP_RISE = (CPOL == CPHA);

   typedef enum logic {S_IDLE, S_ACTIVE} state_t;
   state_t state, state_nx;

   logic [1:0] clk_sy, cs_sy, pico_sy;
   logic clk_d, cs_d;
   logic sclk, csn, pico, rise, fall;
   logic cs_fall, cs_rise, live, smp, sft;
   logic tx_load, push, pop, empty, full, word_done;
   logic [AW:0] wp, rp;
   logic [WORD_W-1:0] mem [TX_DEPTH];
   logic [WORD_W-1:0] tx_sh, rx_sh, rx_word;
   logic [CW-1:0] bitcnt;
   logic ld_pend, skip;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sy  <= {2{CLK_IDLE}};
         cs_sy   <= 2'b11;
         pico_sy <= 2'b00;
         clk_d   <= CLK_IDLE;
         cs_d    <= 1'b1;
      end else begin
         clk_sy  <= {clk_sy[0], SPI_CLK};
         cs_sy   <= {cs_sy[0], SPI_CS};
         pico_sy <= {pico_sy[0], SPI_PICO};
         clk_d   <= clk_sy[1];
         cs_d    <= cs_sy[1];
      end
   end

   assign sclk    = clk_sy[1];
   assign csn     = cs_sy[1];
   assign pico    = pico_sy[1];
   assign rise    = sclk & ~clk_d;
   assign fall    = ~sclk & clk_d;
   assign cs_fall = ~csn & cs_d;
   assign cs_rise = csn & ~cs_d;
   // SPI edges only count inside a frame; one coincident with CS rising is dropped
   assign live    = (state == S_ACTIVE) & ~csn;
   assign smp     = live & (SMP_RISE ? rise : fall);
   assign sft     = live & (SMP_RISE ? fall : rise);
   assign word_done = smp & (bitcnt == LAST);
   assign rx_word = {rx_sh[WORD_W-2:0], pico};

   assign empty = (wp == rp);
   assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign push  = tx_valid & ~full;
   assign pop   = tx_load & ~empty;
   assign tx_ready = ~full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:   if (cs_fall) state_nx = S_ACTIVE;
         S_ACTIVE: if (cs_rise) state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      spi_poci_oe = (state == S_ACTIVE);
      SPI_POCI    = spi_poci_oe & tx_sh[WORD_W-1];
      tx_load     = ((state == S_IDLE) & cs_fall) | (sft & ld_pend & ~skip);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop)  rp <= rp + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wp[AW-1:0]] <= tx_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bitcnt      <= '0;
         rx_sh       <= '0;
         tx_sh       <= '0;
         ld_pend     <= 1'b0;
         skip        <= 1'b0;
         frame_cnt   <= 8'd0;
         frame_abort <= 1'b0;
         tx_underrun <= 1'b0;
      end else begin
         frame_abort <= 1'b0;
         tx_underrun <= tx_load & empty;
         if (tx_load) begin
            tx_sh   <= empty ? FILL_WORD : mem[rp[AW-1:0]];
            ld_pend <= 1'b0;
         end else if (sft) begin
            if (skip) skip <= 1'b0;
            else      tx_sh <= {tx_sh[WORD_W-2:0], 1'b0};
         end
         if (smp) begin
            rx_sh  <= rx_word;
            bitcnt <= word_done ? '0 : bitcnt + 1'b1;
            if (word_done) ld_pend <= 1'b1;
         end
         if ((state == S_IDLE) && cs_fall) begin
            bitcnt <= '0;
            skip   <= (CPHA != 0);
         end
         if ((state == S_ACTIVE) && cs_rise) begin
            frame_abort <= (bitcnt != '0);
            frame_cnt   <= frame_cnt + 8'd1;
            bitcnt      <= '0;
            ld_pend     <= 1'b0;
         end
      end
   end

   // A word landing in the same cycle as a consume takes the freed slot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         rx_overrun <= 1'b0;
      end else begin
         rx_overrun <= 1'b0;
         if (word_done) begin
            if (!rx_valid || rx_ready) begin
               rx_data  <= rx_word;
               rx_valid <= 1'b1;
            end else begin
               rx_overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_spi_target_stream.sv
// Directed bench: four 8-bit instances (modes 0..3) plus a 16-bit, 2-deep one.
// A bit-banged SPI controller drives one chip select at a time.
module tb_spi_target_stream;

   localparam int HP = 100;

   logic clk, rst, rst4, sclk, pico;
   logic [31:0] txd;
   logic cs [5];
   logic txv [5];
   logic rxr [5];
   logic poci [5];
   logic oe [5];
   logic txr [5];
   logic rxv [5];
   logic ovr [5];
   logic udr [5];
   logic abt [5];
   logic [7:0] fcnt [5];
   logic [7:0] rxd8 [4];
   logic [15:0] rxd16;

   logic [31:0] mosi_w [4];
   logic [31:0] miso_w [4];
   logic [31:0] rxlog [$];
   int ovr_n, udr_n, abt_n;
   int total, bad;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int P = g / 2;
      localparam int H = g % 2;
      spi_target_stream #(
         .WORD_W(8), .CPOL(P), .CPHA(H), .TX_DEPTH(4),
         .FILL_WORD(g == 1 ? 8'hFF : 8'h00)
      ) u_dut (
         .clk(clk), .rst(rst),
         .SPI_CLK(P != 0 ? ~sclk : sclk), .SPI_CS(cs[g]), .SPI_PICO(pico),
         .SPI_POCI(poci[g]), .spi_poci_oe(oe[g]),
         .tx_data(txd[7:0]), .tx_valid(txv[g]), .tx_ready(txr[g]),
         .rx_data(rxd8[g]), .rx_valid(rxv[g]), .rx_ready(rxr[g]),
         .rx_overrun(ovr[g]), .tx_underrun(udr[g]),
         .frame_abort(abt[g]), .frame_cnt(fcnt[g])
      );
   end

   spi_target_stream #(
      .WORD_W(16), .CPOL(0), .CPHA(0), .TX_DEPTH(2), .FILL_WORD(16'h0000)
   ) u_wide (
      .clk(clk), .rst(rst4),
      .SPI_CLK(sclk), .SPI_CS(cs[4]), .SPI_PICO(pico),
      .SPI_POCI(poci[4]), .spi_poci_oe(oe[4]),
      .tx_data(txd[15:0]), .tx_valid(txv[4]), .tx_ready(txr[4]),
      .rx_data(rxd16), .rx_valid(rxv[4]), .rx_ready(rxr[4]),
      .rx_overrun(ovr[4]), .tx_underrun(udr[4]),
      .frame_abort(abt[4]), .frame_cnt(fcnt[4])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++)
         if (rxv[i] && rxr[i]) rxlog.push_back({24'd0, rxd8[i]});
      if (rxv[4] && rxr[4]) rxlog.push_back({16'd0, rxd16});
      for (int i = 0; i < 5; i++) begin
         ovr_n += int'(ovr[i]);
         udr_n += int'(udr[i]);
         abt_n += int'(abt[i]);
      end
   end

   task automatic push(input int idx, input logic [31:0] d);
      @(negedge clk);
      txd = d;
      txv[idx] = 1'b1;
      @(negedge clk);
      txv[idx] = 1'b0;
   endtask

   // stop_at > 0 releases CS after that many bits
   task automatic spi_frame(input int idx, input int w, input int nw,
                            input bit cpha, input int stop_at);
      int nb;
      nb = 0;
      @(negedge clk);
      cs[idx] = 1'b0;
      #(HP);
      for (int k = 0; k < nw; k++) begin
         miso_w[k] = '0;
         for (int b = w - 1; b >= 0; b--) begin
            if (stop_at == 0 || nb < stop_at) begin
               if (!cpha) begin
                  pico = mosi_w[k][b];
                  #(HP);
                  sclk = 1'b1;
                  miso_w[k][b] = poci[idx];
                  #(HP);
                  sclk = 1'b0;
               end else begin
                  sclk = 1'b1;
                  #(HP / 2);
                  pico = mosi_w[k][b];
                  #(HP / 2);
                  sclk = 1'b0;
                  miso_w[k][b] = poci[idx];
                  #(HP);
               end
               nb++;
            end
         end
      end
      #(HP);
      cs[idx] = 1'b1;
      #(4 * HP);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 5; i++) begin
         total++;
         if (oe[i] !== 1'b0 || poci[i] !== 1'b0) begin
            bad++;
            $display("FAIL reset_pins[%0d] got oe=%b poci=%b want 0 0", i, oe[i], poci[i]);
         end
         total++;
         if (txr[i] !== 1'b1 || rxv[i] !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags[%0d] got txr=%b rxv=%b want 1 0", i, txr[i], rxv[i]);
         end
         total++;
         if (fcnt[i] !== 8'd0) begin
            bad++;
            $display("FAIL reset_fcnt[%0d] got %0d want 0", i, fcnt[i]);
         end
      end
   endtask

   task automatic test_mode0();
      int base;
      push(0, 32'hA5);
      mosi_w[0] = 32'h3C;
      base = rxlog.size();
      spi_frame(0, 8, 1, 1'b0, 0);
      total++;
      if (miso_w[0][7:0] !== 8'hA5) begin
         bad++;
         $display("FAIL m0_poci got %h want a5", miso_w[0][7:0]);
      end
      total++;
      if (rxlog.size() != base + 1 || rxlog[base] !== 32'h3C) begin
         bad++;
         $display("FAIL m0_rx got n=%0d d=%h want n=1 d=3c", rxlog.size() - base,
                  rxlog.size() > base ? rxlog[base] : 32'hx);
      end
      total++;
      if (fcnt[0] !== 8'd1) begin
         bad++;
         $display("FAIL m0_fcnt got %0d want 1", fcnt[0]);
      end
   endtask

   task automatic test_modes();
      int base;
      for (int m = 1; m < 4; m++) begin
         push(m, 32'h81);
         push(m, 32'h7E);
         mosi_w[0] = 32'h12;
         mosi_w[1] = 32'h34;
         base = rxlog.size();
         spi_frame(m, 8, 2, 1'(m % 2), 0);
         total++;
         if (miso_w[0][7:0] !== 8'h81 || miso_w[1][7:0] !== 8'h7E) begin
            bad++;
            $display("FAIL mode%0d_poci got %h %h want 81 7e", m,
                     miso_w[0][7:0], miso_w[1][7:0]);
         end
         total++;
         if (rxlog.size() != base + 2) begin
            bad++;
            $display("FAIL mode%0d_rxn got %0d want 2", m, rxlog.size() - base);
         end else if (rxlog[base] !== 32'h12 || rxlog[base+1] !== 32'h34) begin
            bad++;
            $display("FAIL mode%0d_rx got %h %h want 12 34", m,
                     rxlog[base], rxlog[base+1]);
         end
      end
   endtask

   task automatic test_fill();
      int u0;
      u0 = udr_n;
      mosi_w[0] = 32'h55;
      mosi_w[1] = 32'hAA;
      spi_frame(1, 8, 2, 1'b1, 0);
      total++;
      if (miso_w[0][7:0] !== 8'hFF || miso_w[1][7:0] !== 8'hFF) begin
         bad++;
         $display("FAIL fill_poci got %h %h want ff ff", miso_w[0][7:0], miso_w[1][7:0]);
      end
      total++;
      if (udr_n - u0 != 2) begin
         bad++;
         $display("FAIL fill_underrun got %0d want 2", udr_n - u0);
      end
   endtask

   task automatic test_overrun();
      int base, o0;
      base = rxlog.size();
      o0 = ovr_n;
      rxr[0] = 1'b0;
      mosi_w[0] = 32'h01;
      mosi_w[1] = 32'h02;
      mosi_w[2] = 32'h03;
      spi_frame(0, 8, 3, 1'b0, 0);
      total++;
      if (rxv[0] !== 1'b1 || rxd8[0] !== 8'h01) begin
         bad++;
         $display("FAIL ovr_hold got v=%b d=%h want 1 01", rxv[0], rxd8[0]);
      end
      total++;
      if (ovr_n - o0 != 2) begin
         bad++;
         $display("FAIL ovr_pulses got %0d want 2", ovr_n - o0);
      end
      @(negedge clk);
      rxr[0] = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if (rxv[0] !== 1'b0 || rxlog.size() != base + 1) begin
         bad++;
         $display("FAIL ovr_drain got v=%b n=%0d want 0 1", rxv[0], rxlog.size() - base);
      end else if (rxlog[base] !== 32'h01) begin
         bad++;
         $display("FAIL ovr_drain_data got %h want 01", rxlog[base]);
      end
   endtask

   task automatic test_abort();
      int base, a0;
      logic [7:0] f0;
      base = rxlog.size();
      a0 = abt_n;
      f0 = fcnt[0];
      mosi_w[0] = 32'hF0;
      spi_frame(0, 8, 1, 1'b0, 5);
      total++;
      if (abt_n - a0 != 1) begin
         bad++;
         $display("FAIL abort_pulse got %0d want 1", abt_n - a0);
      end
      total++;
      if (rxv[0] !== 1'b0 || rxlog.size() != base) begin
         bad++;
         $display("FAIL abort_norx got v=%b n=%0d want 0 0", rxv[0], rxlog.size() - base);
      end
      total++;
      if (fcnt[0] !== f0 + 8'd1) begin
         bad++;
         $display("FAIL abort_fcnt got %0d want %0d", fcnt[0], f0 + 8'd1);
      end
      push(0, 32'h5A);
      mosi_w[0] = 32'hC3;
      spi_frame(0, 8, 1, 1'b0, 0);
      total++;
      if (miso_w[0][7:0] !== 8'h5A || rxlog.size() != base + 1) begin
         bad++;
         $display("FAIL abort_next got poci=%h n=%0d want 5a 1", miso_w[0][7:0],
                  rxlog.size() - base);
      end else if (rxlog[base] !== 32'hC3 || abt_n - a0 != 1) begin
         bad++;
         $display("FAIL abort_next_rx got %h aborts=%0d want c3 1", rxlog[base], abt_n - a0);
      end
      total++;
      if (fcnt[0] !== f0 + 8'd2) begin
         bad++;
         $display("FAIL abort_next_fcnt got %0d want %0d", fcnt[0], f0 + 8'd2);
      end
   endtask

   task automatic test_wide_reset();
      int base;
      push(4, 32'h1111);
      total++;
      if (txr[4] !== 1'b1) begin
         bad++;
         $display("FAIL wide_ready1 got %b want 1", txr[4]);
      end
      push(4, 32'h2222);
      total++;
      if (txr[4] !== 1'b0) begin
         bad++;
         $display("FAIL wide_full got %b want 0", txr[4]);
      end
      push(4, 32'h3333);
      total++;
      if (txr[4] !== 1'b0) begin
         bad++;
         $display("FAIL wide_full3 got %b want 0", txr[4]);
      end
      @(negedge clk);
      cs[4] = 1'b0;
      #(2 * HP);
      for (int b = 0; b < 6; b++) begin
         pico = 1'b1;
         #(HP);
         sclk = 1'b1;
         #(HP);
         sclk = 1'b0;
      end
      #(HP);
      total++;
      if (oe[4] !== 1'b1) begin
         bad++;
         $display("FAIL wide_midframe_oe got %b want 1", oe[4]);
      end
      rst4 = 1'b1;
      #1;
      total++;
      if (oe[4] !== 1'b0 || poci[4] !== 1'b0 || rxv[4] !== 1'b0) begin
         bad++;
         $display("FAIL wide_rst_pins got oe=%b poci=%b rxv=%b want 0 0 0",
                  oe[4], poci[4], rxv[4]);
      end
      total++;
      if (txr[4] !== 1'b1 || fcnt[4] !== 8'd0) begin
         bad++;
         $display("FAIL wide_rst_state got txr=%b fcnt=%0d want 1 0", txr[4], fcnt[4]);
      end
      #(2 * HP);
      cs[4] = 1'b1;
      #(HP);
      @(negedge clk);
      rst4 = 1'b0;
      push(4, 32'hBEEF);
      mosi_w[0] = 32'h1234;
      base = rxlog.size();
      spi_frame(4, 16, 1, 1'b0, 0);
      total++;
      if (miso_w[0][15:0] !== 16'hBEEF) begin
         bad++;
         $display("FAIL wide_poci got %h want beef", miso_w[0][15:0]);
      end
      total++;
      if (rxlog.size() != base + 1 || fcnt[4] !== 8'd1) begin
         bad++;
         $display("FAIL wide_frame got n=%0d fcnt=%0d want 1 1", rxlog.size() - base, fcnt[4]);
      end else if (rxlog[base] !== 32'h1234) begin
         bad++;
         $display("FAIL wide_rx got %h want 1234", rxlog[base]);
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      ovr_n = 0;
      udr_n = 0;
      abt_n = 0;
      rst = 1'b1;
      rst4 = 1'b1;
      sclk = 1'b0;
      pico = 1'b0;
      txd = '0;
      for (int i = 0; i < 5; i++) begin
         cs[i] = 1'b1;
         txv[i] = 1'b0;
         rxr[i] = 1'b1;
      end
      repeat (4) @(negedge clk);
      test_reset();
      rst = 1'b0;
      rst4 = 1'b0;
      repeat (4) @(negedge clk);
      test_mode0();
      test_modes();
      test_fill();
      test_overrun();
      test_abort();
      test_wide_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
